// File: rtl/ad9648_emu.sv
// Dual-channel AD9648-style ADC emulator: ramp / constant / checkerboard / PN16 test
// patterns in bursts or continuously, with warm-up latency, overrange flags and data_valid.
module ad9648_emu #(
  parameter int bit_width = 14,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [bit_width-1:0] const_val,
  input  logic [15:0]          burst_len,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [bit_width-1:0] data_a_bus,
  output logic [bit_width-1:0] data_b_bus,
  output logic                 overrange_a,
  output logic                 overrange_b,
  output logic                 data_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_DONE} state_t;

  localparam logic [15:0] PN_SEED = 16'hACE1;

  // Alternating word with the MSB set (0x2AAA at 14 bits).
  function automatic logic [bit_width-1:0] chk_word();
    logic [bit_width-1:0] w;
    for (int i = 0; i < bit_width; i++) w[i] = (((bit_width - 1 - i) % 2) == 0);
    return w;
  endfunction

  localparam logic [bit_width-1:0] CHK = chk_word();

  function automatic logic [15:0] pn_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // The ramp register's LSB doubles as the sample-parity bit for the checkerboard.
  function automatic logic [bit_width-1:0] pattern(input logic [1:0]           m,
                                                   input logic [bit_width-1:0] ramp,
                                                   input logic [bit_width-1:0] cval,
                                                   input logic [15:0]          lfsr);
    case (m)
      2'd0:    return ramp;
      2'd1:    return cval;
      2'd2:    return ramp[0] ? ~CHK : CHK;
      default: return lfsr[bit_width-1:0];
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [bit_width-1:0] ramp_q, ramp_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [1:0]           mode_q, mode_d;
  logic [bit_width-1:0] cval_q, cval_d;
  logic [15:0]          blen_q, blen_d;

  logic                 busy_q, done_q, vld_q, ovr_a_q, ovr_b_q;
  logic [bit_width-1:0] a_q, b_q;

  logic                 busy_d, done_d, run_d;
  logic [bit_width-1:0] samp;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ramp_d  = ramp_q;
    lfsr_d  = lfsr_q;
    mode_d  = mode_q;
    cval_d  = cval_q;
    blen_d  = blen_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    run_d   = 1'b0;
    samp    = pattern(mode_q, ramp_q, cval_q, lfsr_q);

    case (state_q)
      S_IDLE: begin
        if (start && !enable) begin
          mode_d  = mode;
          cval_d  = const_val;
          blen_d  = burst_len;
          cnt_d   = '0;
          ramp_d  = '0;
          lfsr_d  = PN_SEED;
          state_d = (LATENCY == 0) ? S_RUN : S_WARMUP;
        end
      end
      S_WARMUP: begin
        busy_d = 1'b1;
        if (cnt_q == 16'(LATENCY - 1)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        run_d  = 1'b1;
        ramp_d = ramp_q + bit_width'(1);
        lfsr_d = pn_next(lfsr_q);
        cnt_d  = cnt_q + 16'd1;
        if ((blen_q != 16'd0) && (cnt_q == blen_q - 16'd1)) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Power-down overrides everything, including a pending done pulse.
    if (enable) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      run_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ramp_q  <= '0;
      lfsr_q  <= PN_SEED;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      ovr_a_q <= 1'b0;
      ovr_b_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ramp_q  <= ramp_d;
      lfsr_q  <= lfsr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vld_q   <= run_d;
      ovr_a_q <= run_d && (samp == '1);
      ovr_b_q <= run_d && (samp == '0);
      a_q     <= run_d ? samp : '0;
      b_q     <= run_d ? ~samp : '0;
    end
  end

  // Burst configuration is only captured on an accepted start.
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    cval_q <= cval_d;
    blen_q <= blen_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign data_valid  = vld_q;
  assign overrange_a = ovr_a_q;
  assign overrange_b = ovr_b_q;
  assign data_a_bus  = a_q;
  assign data_b_bus  = b_q;

endmodule

// File: tb/tb_ad9648_emu.sv
// Bench for ad9648_emu: table-driven pattern checks, hand-written abort/reset sequences,
// and randomized bursts compared cycle by cycle against a schedule-based reference model.
module tb_ad9648_emu;
  localparam int BW  = 14;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst, enable, start;
  logic [1:0]    mode;
  logic [BW-1:0] const_val;
  logic [15:0]   burst_len;
  logic          busy, done, data_valid, overrange_a, overrange_b;
  logic [BW-1:0] data_a_bus, data_b_bus;

  ad9648_emu #(.bit_width(BW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .const_val(const_val),
    .burst_len(burst_len), .start(start), .busy(busy), .done(done),
    .data_a_bus(data_a_bus), .data_b_bus(data_b_bus),
    .overrange_a(overrange_a), .overrange_b(overrange_b), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [15:0]   pn_tab [0:4095];
  logic [BW-1:0] cap    [0:63];

  typedef struct {
    logic [1:0]    mode;
    logic [BW-1:0] cval;
    logic [15:0]   blen;
    int            idx;
    logic [BW-1:0] exp_a;
  } vec_t;

  vec_t vt [9];

  // Expected channel-A sample n derived directly from the pattern definitions.
  function automatic logic [BW-1:0] model_a(input logic [1:0] m, input logic [BW-1:0] cv, input int n);
    logic [15:0] s;
    case (m)
      2'd0:    return BW'(n % (1 << BW));
      2'd1:    return cv;
      2'd2:    return ((n % 2) == 0) ? 14'h2AAA : 14'h1555;
      default: begin
        s = pn_tab[n % 4096];
        return s[BW-1:0];
      end
    endcase
  endfunction

  function automatic logic [32:0] mk(input bit bz, input bit dn, input bit vl, input logic [BW-1:0] a);
    logic [BW-1:0] aa, bb;
    aa = vl ? a : '0;
    bb = vl ? ~a : '0;
    return {bz, dn, vl, vl && (a == {BW{1'b1}}), vl && (a == '0), aa, bb};
  endfunction

  function automatic logic [32:0] outs();
    return {busy, done, data_valid, overrange_a, overrange_b, data_a_bus, data_b_bus};
  endfunction

  task automatic chk(input string nm, input int t, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%h want=%h", nm, t, got, exp);
    end
  endtask

  // Drives one start, then checks every cycle against the expected schedule:
  // busy for t=1..LAT+N, valid for t=LAT+1..LAT+N, done at t=LAT+N+1.
  // abort_at >= 0 raises enable after the check at that t; continuous runs always abort.
  task automatic run_burst(input logic [1:0] m, input logic [BW-1:0] cv, input logic [15:0] bl,
                           input int nrun, input int abort_at);
    int  ab, tmax, blen, n;
    bit  aborted, bz, dn, vl;
    logic [BW-1:0] a;
    blen = int'(bl);
    ab   = abort_at;
    if (blen == 0) begin
      ab   = LAT + nrun;
      tmax = LAT + nrun + 2;
    end else begin
      tmax = LAT + blen + 2;
    end
    mode = m; const_val = cv; burst_len = bl; enable = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("start_edge", 0, outs(), mk(0, 0, 0, '0));
    for (int t = 0; t <= tmax; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
        aborted = (ab >= 0) && (t > ab);
        if (aborted) begin
          bz = 0; dn = 0; vl = 0;
        end else if (blen == 0) begin
          bz = 1; dn = 0; vl = (t >= LAT + 1);
        end else begin
          bz = (t <= LAT + blen);
          vl = (t >= LAT + 1) && (t <= LAT + blen);
          dn = (t == LAT + blen + 1);
        end
        n = t - LAT - 1;
        a = vl ? model_a(m, cv, n) : '0;
        chk(vl ? "sample" : "ctrl", t, outs(), mk(bz, dn, vl, a));
        if (vl && n < 64) cap[n] = data_a_bus;
      end
      // Scramble the inputs; none of this may disturb a latched burst.
      mode      = 2'($urandom);
      const_val = BW'($urandom);
      burst_len = 16'($urandom);
      if (ab >= 0 && t >= ab) begin
        enable = 1'b1;
        start  = 1'($urandom);
      end else begin
        enable = 1'b0;
        start  = (blen == 0 || t < LAT + blen) ? 1'($urandom) : 1'b0;
      end
    end
    enable = 1'b0;
    start  = 1'b0;
  endtask

  initial begin
    logic [15:0]   s;
    logic [1:0]    rm;
    logic [BW-1:0] rcv;
    logic [15:0]   rbl;
    int            rn, rab;

    s = 16'hACE1;
    for (int i = 0; i < 4096; i++) begin
      pn_tab[i] = s;
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    end

    vt[0] = '{2'd0, 14'h0000, 16'd5, 0, 14'h0000};
    vt[1] = '{2'd0, 14'h0000, 16'd5, 4, 14'h0004};
    vt[2] = '{2'd1, 14'h1234, 16'd3, 0, 14'h1234};
    vt[3] = '{2'd1, 14'h1234, 16'd3, 2, 14'h1234};
    vt[4] = '{2'd2, 14'h0000, 16'd3, 0, 14'h2AAA};
    vt[5] = '{2'd2, 14'h0000, 16'd3, 1, 14'h1555};
    vt[6] = '{2'd2, 14'h0000, 16'd3, 2, 14'h2AAA};
    vt[7] = '{2'd3, 14'h0000, 16'd2, 0, 14'h2CE1};
    vt[8] = '{2'd3, 14'h0000, 16'd2, 1, 14'h1670};

    // Reset, with start held high to show reset wins.
    rst = 1'b1; enable = 1'b0; start = 1'b1; mode = 2'd0; const_val = '0; burst_len = 16'd4;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 0, outs(), mk(0, 0, 0, '0));
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", 0, outs(), mk(0, 0, 0, '0));

    // Start ignored while powered down.
    enable = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("start_while_disabled", 0, outs(), mk(0, 0, 0, '0));

    for (int i = 0; i < 9; i++) begin
      run_burst(vt[i].mode, vt[i].cval, vt[i].blen, 0, -1);
      chk("table_sample", i, {19'd0, cap[vt[i].idx]}, {19'd0, vt[i].exp_a});
    end

    // Ramp wrap in continuous mode, past 2^14 samples.
    run_burst(2'd0, '0, 16'd0, 16385, -1);

    // Abort on the third sample, then on the final sample (no done either way).
    run_burst(2'd0, '0, 16'd10, 0, LAT + 3);
    run_burst(2'd1, 14'h3FFF, 16'd3, 0, LAT + 3);

    // Reset in the middle of a PN run, then a fresh PN start.
    mode = 2'd3; burst_len = 16'd0; enable = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_run", 0, outs(), mk(0, 0, 0, '0));
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_rst", 0, outs(), mk(0, 0, 0, '0));
    run_burst(2'd3, '0, 16'd2, 0, -1);
    chk("pn_after_rst", 0, {19'd0, cap[0]}, {19'd0, 14'h2CE1});

    // Randomized bursts, some continuous, some aborted.
    for (int i = 0; i < 16; i++) begin
      rm  = 2'($urandom);
      rcv = BW'($urandom);
      rbl = 16'($urandom_range(0, 12));
      rn  = $urandom_range(1, 20);
      rab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, LAT + int'(rbl)) : -1;
      run_burst(rm, rcv, rbl, rn, rab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ad9648_emu.md
AD9648_EMU -- requirements
Module: ad9648_emu

Interface
REQ-001 The block SHALL have parameter bit_width, default 14, setting the sample width of each channel.
REQ-002 The block SHALL have parameter LATENCY, default 4, setting the warm-up cycles between accepted start and first valid sample.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port enable, input, 1, active-low run enable, matching the ADC power-down sense.
REQ-006 The block SHALL have port mode, input, 2, pattern select: 0 ramp, 1 constant, 2 checkerboard, 3 PN16.
REQ-007 The block SHALL have port const_val, input, bit_width, the constant-mode sample value.
REQ-008 The block SHALL have port burst_len, input, 16, samples per burst; 0 means continuous.
REQ-009 The block SHALL have port start, input, 1, a one-cycle request to begin generation.
REQ-010 The block SHALL have port busy, output, 1, high in WARMUP and RUN.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse at burst completion.
REQ-012 The block SHALL have ports data_a_bus and data_b_bus, output, bit_width each, the emulated ADC channel A and B sample buses.
REQ-013 The block SHALL have ports overrange_a and overrange_b, output, 1 each, the emulated overrange flags.
REQ-014 The block SHALL have port data_valid, output, 1, high when the data buses carry a sample.

Function
REQ-015 The block SHALL implement the FSM IDLE -> WARMUP -> RUN -> DONE -> IDLE; all outputs are registered.
REQ-016 In IDLE, start=1 with enable=0 SHALL move the FSM to WARMUP and latch mode, const_val and burst_len; start with enable=1 SHALL be ignored.
REQ-017 start SHALL be ignored in WARMUP, RUN and DONE; input changes after latching SHALL NOT affect the running burst.
REQ-018 WARMUP SHALL last exactly LATENCY cycles, with data and flags 0 and data_valid 0; LATENCY=0 SHALL go directly to RUN.
REQ-019 Each RUN cycle SHALL emit one sample n (n=0,1,...) with data_valid=1, data_b_bus = bitwise NOT of data_a_bus.
REQ-020 In ramp mode, A(n) SHALL equal n mod 2^bit_width, wrapping from all-ones to 0.
REQ-021 In constant mode, A(n) SHALL equal the latched const_val.
REQ-022 In checkerboard mode, A(n) SHALL be the alternating pattern with MSB=1 (0x2AAA at 14 bits) for even n and its inverse for odd n.
REQ-023 In PN16 mode, a Fibonacci LFSR, taps 16,14,13,11, SHALL run with new bit = s[0]^s[2]^s[3]^s[5] and s <= {bit, s[15:1]}.
REQ-024 In PN16 mode, the LFSR SHALL be seeded 16'hACE1 on each accepted start; A(n) = s[bit_width-1:0], advancing once per RUN cycle.
REQ-025 overrange_a SHALL be 1 exactly when data_a_bus is all-ones with data_valid=1, and overrange_b likewise for data_b_bus.
REQ-026 With burst_len=N>0, RUN SHALL emit exactly N samples, then spend one cycle in DONE with done=1, data_valid=0, outputs 0, then return to IDLE.
REQ-027 With burst_len=0, RUN SHALL continue indefinitely; the ramp and sample counter SHALL wrap silently.
REQ-028 enable=1 in any state SHALL force IDLE on the next edge with outputs 0, busy 0 and no done pulse.
REQ-029 When enable=1 coincides with the last burst sample, abort SHALL take precedence and done SHALL NOT pulse.
REQ-030 In IDLE, all data, flags, data_valid, busy and done SHALL be 0.

Reset
REQ-031 rst=1 SHALL force IDLE, all outputs 0, counters 0 and LFSR to 16'hACE1 on the next edge, from any state including mid-RUN.
REQ-032 rst SHALL take precedence over start and enable.

Verification (bit_width=14, LATENCY=4, start sampled at edge k)
REQ-033 Ramp burst: mode=0, burst_len=5 -> valid at k+5..k+9, A=0..4, B=0x3FFF..0x3FFB, overrange_b=1 at k+5 only, done at k+10, busy k+1..k+9.
REQ-034 Ramp wrap: mode=0, burst_len=0, run 16385 samples -> A=0x3FFF with overrange_a=1, then A=0x0000, B=0x3FFF with overrange_b=1.
REQ-035 Constant and checkerboard: mode=1, const_val=0x1234, burst_len=3 -> A=0x1234 x3, B=0x2DCB; mode=2 -> A=0x2AAA, 0x1555, 0x2AAA.
REQ-036 PN16: mode=3 -> A(0)=0x2CE1, A(1)=0x1670.
REQ-037 Abort: enable=1 at third RUN sample -> next cycle valid=0, outputs 0, busy=0, no done pulse; start with enable=1 stays in IDLE.
REQ-038 Reset mid-RUN: rst=1 -> all outputs 0 next cycle; a fresh PN start reproduces A(0)=0x2CE1.
